// File: rtl/mor1kx_tlb_reload_arbiter.sv
// mor1kx_tlb_reload_arbiter: shares one walk read port between the IMMU
// and DMMU TLB reload engines, locking the grant for a whole page walk.
module mor1kx_tlb_reload_arbiter #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,

  input  logic immu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] immu_addr_i,
  output logic immu_ack_o,
  output logic immu_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] immu_dat_o,

  input  logic dmmu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dmmu_addr_i,
  output logic dmmu_ack_o,
  output logic dmmu_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dmmu_dat_o,

  output logic bus_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] bus_addr_o,
  input  logic bus_ack_i,
  input  logic bus_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] bus_dat_i,

  output logic busy_o,
  output logic owner_o
);

  localparam int W = OPTION_OPERAND_WIDTH;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST =
    TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t state;
  logic [TIMEOUT_WIDTH-1:0] cnt;

  logic owner_req;
  logic [W-1:0] owner_addr;
  logic win;
  logic [W-1:0] win_addr;
  logic timeout;
  logic fail;
  logic done;

  assign owner_req  = owner_o ? dmmu_req_i : immu_req_i;
  assign owner_addr = owner_o ? dmmu_addr_i : immu_addr_i;

  // On a tie the side that did not own the bus last wins.
  assign win = (immu_req_i && dmmu_req_i) ? ~owner_o : dmmu_req_i;
  assign win_addr = win ? dmmu_addr_i : immu_addr_i;

  assign timeout = TO_EN && (cnt == CNT_LAST);
  assign fail    = bus_err_i || timeout;
  assign done    = fail || bus_ack_i;

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner_o    <= 1'b1;
      bus_req_o  <= 1'b0;
      bus_addr_o <= '0;
      immu_ack_o <= 1'b0;
      immu_err_o <= 1'b0;
      immu_dat_o <= '0;
      dmmu_ack_o <= 1'b0;
      dmmu_err_o <= 1'b0;
      dmmu_dat_o <= '0;
    end else begin
      immu_ack_o <= 1'b0;
      immu_err_o <= 1'b0;
      dmmu_ack_o <= 1'b0;
      dmmu_err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (immu_req_i || dmmu_req_i) begin
            owner_o    <= win;
            bus_addr_o <= win_addr;
            bus_req_o  <= 1'b1;
            cnt        <= '0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          cnt        <= cnt + TIMEOUT_WIDTH'(1);
          bus_addr_o <= owner_addr;
          if (done) begin
            bus_req_o <= 1'b0;
            state     <= RECOVER;
            // A walker that dropped its request gets no response.
            if (owner_req) begin
              if (fail) begin
                if (owner_o) dmmu_err_o <= 1'b1;
                else immu_err_o <= 1'b1;
              end else if (owner_o) begin
                dmmu_ack_o <= 1'b1;
                dmmu_dat_o <= bus_dat_i;
              end else begin
                immu_ack_o <= 1'b1;
                immu_dat_o <= bus_dat_i;
              end
            end
          end
        end
        RECOVER: begin
          if (owner_req) begin
            bus_addr_o <= owner_addr;
            bus_req_o  <= 1'b1;
            cnt        <= '0;
            state      <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mor1kx_tlb_reload_arbiter.md
Name: mor1kx_tlb_reload_arbiter

Overview:
- Shares one memory read port between the hardware TLB reload walkers of the IMMU and the DMMU.
- Arbitrates round-robin and locks the grant to the owner for its whole multi-access page walk (PTE-pointer fetch, then PTE fetch).
- Forwards ack, data and error back to the owner only.
- Sits between both MMUs' tlb_reload_* ports and the core's walk bus master.

Parameters:
- OPTION_OPERAND_WIDTH, 32, address/data width.
- TIMEOUT_CYCLES, 255, max cycles an access may wait for bus_ack_i/bus_err_i before it is aborted with an error; 0 disables the watchdog.
- TIMEOUT_WIDTH, 8, counter width; must satisfy TIMEOUT_CYCLES <= 2^TIMEOUT_WIDTH-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- immu_req_i  in  1  IMMU reload request, held high for the whole walk
- immu_addr_i  in  OPTION_OPERAND_WIDTH  IMMU access address
- immu_ack_o  out  1  one-cycle completion pulse to IMMU
- immu_err_o  out  1  one-cycle error pulse to IMMU (bus error or timeout)
- immu_dat_o  out  OPTION_OPERAND_WIDTH  read data to IMMU, valid with ack
- dmmu_req_i, dmmu_addr_i, dmmu_ack_o, dmmu_err_o, dmmu_dat_o  same widths/meaning for DMMU
- bus_req_o  out  1  access request to memory
- bus_addr_o  out  OPTION_OPERAND_WIDTH  access address
- bus_ack_i  in  1  access done, bus_dat_i valid
- bus_err_i  in  1  access failed
- bus_dat_i  in  OPTION_OPERAND_WIDTH  read data
- busy_o  out  1  walk in progress (state != IDLE)
- owner_o  out  1  current/last owner: 0 = IMMU, 1 = DMMU

Behaviour:
- Reset (async, rst high):
  - state = IDLE; all ack/err outputs 0; bus_req_o 0; bus_addr_o 0; *_dat_o 0.
  - Timeout counter 0; owner_o 1, so IMMU wins the first tie.
- States: IDLE, ACCESS, RECOVER.
- IDLE:
  - Only one req high: grant that requester.
  - Both high: grant the one not equal to owner_o (round-robin).
  - On grant: owner_o <= winner; bus_addr_o <= winner addr; bus_req_o <= 1; go ACCESS.
  - Grant-to-bus_req_o latency is 1 cycle.
- ACCESS:
  - bus_req_o held 1; bus_addr_o tracks the owner's addr combinationally-registered each cycle. Owner must hold addr stable.
  - bus_ack_i: owner ack_o pulses 1 cycle later (registered); dat_o <= bus_dat_i; bus_req_o <= 0; go RECOVER.
  - bus_err_i, or counter reaching TIMEOUT_CYCLES (when nonzero): owner err_o pulses; no ack; bus_req_o <= 0; go RECOVER.
  - ack and err in the same cycle: err wins, ack suppressed.
  - Counter increments each ACCESS cycle and clears on entry to ACCESS.
- RECOVER:
  - Lasts exactly 1 cycle with bus_req_o 0, so the owner can update its address after the ack.
  - Owner req still high: stay granted; reload bus_addr_o; bus_req_o <= 1; go ACCESS. The lock holds even if the other requester is waiting.
  - Owner req low: go IDLE, bus idle; the other requester can be granted on the following cycle.
- Owner drops req during ACCESS (walker reset or pagefault clear):
  - Outstanding access still completes.
  - Ack/err is discarded (not forwarded), then go IDLE via RECOVER.
- Non-owner outputs: ack_o, err_o and dat_o never change for the non-owner. dat_o holds its last value between acks.
- At most one ack_o/err_o pulse per bus access; no pulse while bus_req_o is 0.
- bus_ack_i/bus_err_i while not in ACCESS are ignored.
- Reset asserted mid-walk: immediate return to reset values; no pulses emitted.

Test Plan:
- IMMU-only walk: immu_req=1, addr 0x1000_0004, ack with data 0x2000_0000 after 3 cycles.
  - Required: immu_ack_o pulses once with dat 0x2000_0000.
  - Required: bus_req_o low 1 cycle, then high with the new addr 0x2000_0ABC; second ack gives a second pulse.
  - Required: drop req -> IDLE, busy_o 0.
- Simultaneous requests from reset: IMMU granted first. After IMMU drops req, DMMU granted 2 cycles later. Next tie grants IMMU again.
- Lock: DMMU raises req during IMMU RECOVER -> IMMU keeps the bus for its second access. dmmu_ack_o stays 0 throughout.
- Bus error: bus_err_i=1 with bus_ack_i=1 -> owner err_o pulses, ack_o stays 0, state RECOVER.
- Timeout: TIMEOUT_CYCLES=4, no ack -> err_o pulses after exactly 4 ACCESS cycles, bus_req_o drops. A late bus_ack_i is ignored.
- Async reset mid-ACCESS -> bus_req_o 0 immediately with no clock edge; owner_o 1; no ack/err pulses follow.
